// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-8 demux dispatch controller.
package demux_pkg;

    localparam int N_LANES = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dispatch_state_t;

    // Returns {none, idx}: first enabled lane at or after ptr, wrapping mod N_LANES.
    function automatic logic [SEL_W:0] rr_pick(input logic [SEL_W-1:0] ptr,
                                               input logic [N_LANES-1:0] mask);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_LANES; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {~found, idx};
    endfunction

endpackage

// File: rtl/rr_lane_picker.sv
// Combinational round-robin lane picker over an 8-lane enable mask.
module rr_lane_picker
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0]   ptr,
    input  logic [N_LANES-1:0] mask,
    output logic [SEL_W-1:0]   idx,
    output logic               none
);

    assign {none, idx} = rr_pick(ptr, mask);

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Dispatch controller: holds one word and presents it on a single lane of the 1-to-8 demux
// until that lane accepts it, with fixed or round-robin lane choice.
module demux_dispatch_ctrl
    import demux_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    input  logic [DW-1:0]      s_data,
    output logic               s_ready,
    input  logic               mode_rr,
    input  logic [SEL_W-1:0]   dest_sel,
    input  logic [N_LANES-1:0] dest_en,
    output logic [N_LANES-1:0] m_valid,
    output logic [DW-1:0]      m_data,
    input  logic [N_LANES-1:0] m_ready,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               busy,
    output logic [CNT_W-1:0]   sent_cnt
);

    dispatch_state_t  state;
    dispatch_state_t  state_next;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_none;
    logic [SEL_W-1:0] tgt;
    logic             ready_en;
    logic             complete;
    logic             accept;

    // A word accepted in the same cycle another completes must already see the advanced
    // pointer, otherwise back-to-back RR traffic would land twice on the same lane.
    assign pick_ptr = (complete && mode_rr) ? cur_sel + 1'b1 : rr_ptr;

    rr_lane_picker u_picker (
        .ptr  (pick_ptr),
        .mask (dest_en),
        .idx  (rr_idx),
        .none (rr_none)
    );

    assign tgt  = mode_rr ? rr_idx : dest_sel;
    assign busy = (state == SEND);

    always_comb begin
        state_next = state;
        complete   = (state == SEND) && m_ready[cur_sel];
        s_ready    = ready_en && ((state == IDLE) || complete) && !(mode_rr && rr_none);
        accept     = s_valid && s_ready;
        if (accept) begin
            state_next = SEND;
        end else if (complete) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ready_en keeps s_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            m_valid  <= '0;
            m_data   <= '0;
            cur_sel  <= '0;
            rr_ptr   <= '0;
            sent_cnt <= '0;
        end else begin
            ready_en <= 1'b1;
            if (complete) begin
                sent_cnt <= sent_cnt + 1'b1;
                if (mode_rr) begin
                    rr_ptr <= cur_sel + 1'b1;
                end
            end
            if (accept) begin
                m_data  <= s_data;
                cur_sel <= tgt;
                m_valid <= N_LANES'(1) << tgt;
            end else if (complete) begin
                m_valid <= '0;
            end
        end
    end

endmodule
